// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops and optional iterative mul/div.
// Define ALU_SEQ_MULDIV_EN to build the bit-serial multiplier/divider.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             data_exception
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, sum, dif;
    logic neq_q, neq_d, lt_q, lt_d, ovf_q, ovf_d, exc_q, exc_d;
`ifdef ALU_SEQ_MULDIV_EN
    logic [2*WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, mul_acc, mul_full;
    logic [WIDTH-1:0] ra_q, ra_d, a_mag, b_mag, quo, div_res;
    logic [WIDTH:0] rem_s, rem_n;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic neg_q, neg_d, isdiv_q, isdiv_d, mul_ovf, div_ovf, div_ge;
    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    // multiply: shift-add on magnitudes, sign applied after the last step
    assign mul_acc = acc_q + (ra_q[0] ? mc_q : '0);
    assign mul_full = neg_q ? -mul_acc : mul_acc;
    assign mul_ovf = !((&mul_full[2*WIDTH-1:WIDTH-1]) || !(|mul_full[2*WIDTH-1:WIDTH-1]));
    // divide: restoring, quotient bits shift into ra_q as dividend bits leave
    assign rem_s = {acc_q[WIDTH-1:0], ra_q[WIDTH-1]};
    assign div_ge = rem_s >= {1'b0, mc_q[WIDTH-1:0]};
    assign rem_n = div_ge ? rem_s - {1'b0, mc_q[WIDTH-1:0]} : rem_s;
    assign quo = {ra_q[WIDTH-2:0], div_ge};
    assign div_res = neg_q ? -quo : quo;
    assign div_ovf = !neg_q && quo[WIDTH-1];
`endif
    assign sum = data_operandA + data_operandB;
    assign dif = data_operandA - data_operandB;

    always_comb begin
        state_d = state_q;
        res_d = res_q;
        neq_d = neq_q;
        lt_d = lt_q;
        ovf_d = ovf_q;
        exc_d = exc_q;
`ifdef ALU_SEQ_MULDIV_EN
        acc_d = acc_q;
        mc_d = mc_q;
        ra_d = ra_q;
        cnt_d = cnt_q;
        neg_d = neg_q;
        isdiv_d = isdiv_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = DONE;
                neq_d = data_operandA != data_operandB;
                lt_d = $signed(data_operandA) < $signed(data_operandB);
                ovf_d = 1'b0;
                exc_d = 1'b0;
                res_d = '0;
                case (ctrl_ALUopcode)
                    5'd0: begin
                        res_d = sum;
                        ovf_d = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) && (sum[WIDTH-1] != data_operandA[WIDTH-1]);
                    end
                    5'd1: begin
                        res_d = dif;
                        ovf_d = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) && (dif[WIDTH-1] != data_operandA[WIDTH-1]);
                    end
                    5'd2: res_d = data_operandA & data_operandB;
                    5'd3: res_d = data_operandA | data_operandB;
                    5'd4: res_d = data_operandA << ctrl_shiftamt;
                    5'd5: res_d = $signed(data_operandA) >>> ctrl_shiftamt;
`ifdef ALU_SEQ_MULDIV_EN
                    5'd6: begin
                        state_d = BUSY;
                        acc_d = '0;
                        mc_d = {{WIDTH{1'b0}}, a_mag};
                        ra_d = b_mag;
                        cnt_d = SHW'(WIDTH - 1);
                        neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        isdiv_d = 1'b0;
                    end
                    5'd7: if (data_operandB == '0) exc_d = 1'b1;
                    else begin
                        state_d = BUSY;
                        acc_d = '0;
                        mc_d = {{WIDTH{1'b0}}, b_mag};
                        ra_d = a_mag;
                        cnt_d = SHW'(WIDTH - 1);
                        neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        isdiv_d = 1'b1;
                    end
`endif
                    default: exc_d = 1'b1;
                endcase
            end
`ifdef ALU_SEQ_MULDIV_EN
            BUSY: begin
                acc_d = isdiv_q ? {{(WIDTH-1){1'b0}}, rem_n} : mul_acc;
                mc_d = isdiv_q ? mc_q : mc_q << 1;
                ra_d = isdiv_q ? quo : ra_q >> 1;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    res_d = isdiv_q ? div_res : mul_full[WIDTH-1:0];
                    ovf_d = isdiv_q ? div_ovf : mul_ovf;
                end
            end
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            res_q <= '0;
            neq_q <= 1'b0;
            lt_q <= 1'b0;
            ovf_q <= 1'b0;
            exc_q <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            acc_q <= '0;
            mc_q <= '0;
            ra_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            isdiv_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            res_q <= res_d;
            neq_q <= neq_d;
            lt_q <= lt_d;
            ovf_q <= ovf_d;
            exc_q <= exc_d;
`ifdef ALU_SEQ_MULDIV_EN
            acc_q <= acc_d;
            mc_q <= mc_d;
            ra_q <= ra_d;
            cnt_q <= cnt_d;
            neg_q <= neg_d;
            isdiv_q <= isdiv_d;
`endif
        end
    end

    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign data_result = res_q;
    assign isNotEqual = neq_q;
    assign isLessThan = lt_q;
    assign overflow = ovf_q;
    assign data_exception = exc_q;
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; SHALL be a power of two, 8..64.
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 data_operandA  input  WIDTH  operand A (shift source).
REQ-008 data_operandB  input  WIDTH  operand B.
REQ-009 ctrl_ALUopcode  input  5  00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra, 00110 mul, 00111 div.
REQ-010 ctrl_shiftamt  input  SHW  shift amount.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 data_result  output  WIDTH  registered result.
REQ-014 isNotEqual, isLessThan, overflow, data_exception  output  1 each  registered flags.

Function
REQ-015 States SHALL be IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 Accept = in_valid & in_ready; operands, opcode and shift amount SHALL be captured at accept and input changes ignored thereafter.
REQ-017 add/sub/and/or/sll/sra/unused opcodes: IDLE->DONE at the accepting edge; out_valid on the next cycle (latency 1).
REQ-018 mul/div: IDLE->BUSY at accept; BUSY lasts exactly WIDTH cycles (one bit per cycle); then DONE (out_valid WIDTH+1 cycles after accept).
REQ-019 DONE->IDLE on the edge where out_ready=1; outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 add/sub: two's-complement, result mod 2^WIDTH; overflow=1 on signed overflow.
REQ-021 sll: logical left; sra: arithmetic right by ctrl_shiftamt; shift amount 0 passes A unchanged.
REQ-022 mul: signed A*B, data_result = low WIDTH bits; overflow=1 iff full 2*WIDTH product is not representable in WIDTH signed bits.
REQ-023 div: signed A/B, quotient truncated toward zero; B=0 -> data_result=0, data_exception=1, BUSY skipped (latency 1); A=MIN, B=-1 -> data_result=MIN, overflow=1.
REQ-024 isNotEqual = (A!=B), isLessThan = signed A<B (correct even when A-B overflows), for every opcode.
REQ-025 overflow=0 for and/or/sll/sra; data_exception=0 except REQ-023 and REQ-030.
REQ-026 Unused opcodes 01000..11111: data_result=0, overflow=0, data_exception=1.
REQ-027 in_valid while not IDLE SHALL be ignored (no queueing).

Reset
REQ-028 reset SHALL immediately force IDLE, in_ready=1, out_valid=0, data_result=0, all flags 0.
REQ-029 reset during BUSY or DONE SHALL abort the operation; no result is produced for it after release.

Configuration
REQ-030 Macro ALU_SEQ_MULDIV_EN: defined -> mul/div per REQ-018/022/023; undefined -> no iterative hardware, opcodes 00110/00111 complete in 1 cycle with data_result=0, overflow=0, data_exception=1, BUSY unreachable.

Verification (WIDTH=32)
REQ-031 add 0x7FFFFFFF+0x00000001 -> 0x80000000, overflow=1, isLessThan=0, out_valid 1 cycle after accept.
REQ-032 sra 0x80000000 by 4 -> 0xF8000000; sll 0x00000001 by 31 -> 0x80000000; sub 0x80000000-0x00000001 -> isLessThan=1, overflow=1.
REQ-033 mul 0xFFFFFFFD*0x00000007 -> 0xFFFFFFEB, overflow=0, out_valid 33 cycles after accept; mul 0x00010000*0x00010000 -> 0x00000000, overflow=1.
REQ-034 div 0xFFFFFFF9/0x00000002 -> 0xFFFFFFFD; div 7/0 -> 0, data_exception=1 after 1 cycle; div 0x80000000/0xFFFFFFFF -> 0x80000000, overflow=1.
REQ-035 Hold out_ready=0 for 5 cycles -> data_result stable, in_ready=0, new in_valid ignored; assert reset at cycle 10 of a div -> out_valid=0, in_ready=1 immediately, no result after release.
REQ-036 Build without ALU_SEQ_MULDIV_EN: mul 3*4 -> 0, data_exception=1, out_valid 1 cycle after accept.
